// File: rtl/final_bitstream_packer.sv
// Byte serialiser for 16-bit bitstream words with end-of-frame final-word stitching.
// Stream words queue in a small FIFO; on flush, the captured final words follow the queued words.
module final_bitstream_packer #(
    parameter int unsigned OUTPUT_BITSTREAM_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH             = 4,
    parameter int unsigned COUNT_WIDTH            = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_word_valid,
    input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] i_word,
    output logic                              o_word_ready,
    input  logic                              i_flush,
    input  logic [1:0]                        i_flag,
    input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] i_bit_1,
    input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] i_bit_2,
    output logic                              o_byte_valid,
    output logic [7:0]                        o_byte,
    input  logic                              i_byte_ready,
    output logic                              o_last,
    output logic                              o_busy,
    output logic [COUNT_WIDTH-1:0]            o_byte_count,
    output logic                              o_done
);

    localparam int unsigned W        = OUTPUT_BITSTREAM_WIDTH;
    localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [PtrW:0] FifoOne  = (PtrW + 1)'(1);

    typedef enum logic [1:0] {StStream, StDrain, StFinal, StDone} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [W-1:0]           r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]        r_wr_ptr;
    logic [PtrW-1:0]        r_rd_ptr;
    logic [PtrW:0]          r_fill;
    logic                   r_half;
    logic                   r_word_sel;
    logic                   r_rdy_en;
    logic [1:0]             r_flag;
    logic [W-1:0]           r_bit_1;
    logic [W-1:0]           r_bit_2;
    logic [COUNT_WIDTH-1:0] r_byte_count;

    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    logic         w_fire;
    logic         w_capture;
    logic         w_drained;
    logic         w_has_final;
    logic         w_last_final;
    logic [W-1:0] w_cur_word;

    assign w_empty      = (r_fill == '0);
    // r_rdy_en keeps ready low until the first clock after reset release.
    assign o_word_ready = r_rdy_en && (r_state == StStream) && (r_fill != FifoFull);
    assign w_push       = i_word_valid && o_word_ready;
    assign w_capture    = (r_state == StStream) && i_flush;

    assign w_cur_word   = (r_state == StFinal) ? (r_word_sel ? r_bit_2 : r_bit_1)
                                               : r_mem[r_rd_ptr];
    assign o_byte_valid = (r_state == StFinal) || !w_empty;
    assign o_byte       = !o_byte_valid ? 8'h00
                        : (r_half ? w_cur_word[7:0] : w_cur_word[W-1:W-8]);
    assign w_fire       = o_byte_valid && i_byte_ready;
    assign w_pop        = w_fire && r_half && (r_state != StFinal);

    // Flag 3 is treated as "no final words".
    assign w_has_final  = (r_flag == 2'd1) || (r_flag == 2'd2);
    assign w_last_final = (r_flag != 2'd2) || r_word_sel;
    assign o_last       = (r_state == StFinal) && r_half && w_last_final;

    // Look ahead on the last pop so the final words follow without a bubble.
    assign w_drained    = w_empty || ((r_fill == FifoOne) && w_pop);

    assign o_busy       = (r_state != StStream) || !w_empty;
    assign o_done       = (r_state == StDone);
    assign o_byte_count = r_byte_count;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StStream: if (i_flush) w_state_next = StDrain;
            StDrain:  if (w_drained) w_state_next = w_has_final ? StFinal : StDone;
            StFinal:  if (w_fire && o_last) w_state_next = StDone;
            StDone:   w_state_next = StStream;
            default:  w_state_next = StStream;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StStream;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_word;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_half       <= 1'b0;
            r_word_sel   <= 1'b0;
            r_rdy_en     <= 1'b0;
            r_flag       <= 2'd0;
            r_bit_1      <= '0;
            r_bit_2      <= '0;
            r_byte_count <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + FifoOne;
            end else if (!w_push && w_pop) begin
                r_fill <= r_fill - FifoOne;
            end
            if (w_fire) begin
                r_half <= !r_half;
            end
            if (w_capture) begin
                r_flag     <= i_flag;
                r_bit_1    <= i_bit_1;
                r_bit_2    <= i_bit_2;
                r_word_sel <= 1'b0;
            end else if ((r_state == StFinal) && w_fire && r_half) begin
                r_word_sel <= 1'b1;
            end
            if (r_state == StDone) begin
                r_byte_count <= '0;
            end else if (w_fire && (r_byte_count != '1)) begin
                r_byte_count <= r_byte_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/final_bitstream_packer.md
Name: final_bitstream_packer

Overview:
Byte-serialisation and end-of-frame stitching stage downstream of the final-bits generator.
- Buffers the encoder's normal 16-bit bitstream words in a small FIFO.
- On a flush request, captures the generator's flag, out_bit_1 and out_bit_2 and emits those words after every buffered stream word.
- Output is a byte stream, MSB byte first, with valid/ready backpressure, a last-byte marker and a completion pulse.

Parameters:
OUTPUT_BITSTREAM_WIDTH, 16, width of stream and final words; fixed at 16 (two bytes per word).
FIFO_DEPTH, 4, stream-word FIFO entries; power of two, at least 2.
COUNT_WIDTH, 16, width of the emitted-byte counter.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
in_word_valid  in  1  stream word present.
in_word  in  16  stream word.
in_word_ready  out  1  FIFO not full and state is STREAM.
in_flush  in  1  one-cycle end-of-frame request.
in_flag  in  2  final-word count from generator: 0 = none, 1 = one word, 2 = two words.
in_bit_1  in  16  first final word.
in_bit_2  in  16  second final word.
out_byte_valid  out  1  byte available.
out_byte  out  8  byte.
out_byte_ready  in  1  consumer accepts byte.
out_last  out  1  qualifies the final byte of the frame.
out_busy  out  1  state is not STREAM, or FIFO/byte path is non-empty.
out_byte_count  out  COUNT_WIDTH  bytes transferred this frame.
out_done  out  1  one-cycle frame-complete pulse.

Behaviour:
- Reset (asynchronous assert, synchronous release) clears all outputs to 0, empties the FIFO and enters STREAM. Reset mid-frame discards all pending bytes; no out_done is produced.
- Transfer rules:
  - A byte transfers when out_byte_valid and out_byte_ready are both high.
  - While out_byte_valid is high and out_byte_ready is low, out_byte and out_last hold stable.
  - A word transfers when in_word_valid and in_word_ready are both high.
- Byte order per word: bits [15:8], then bits [7:0].
- Latency: a word accepted at edge N into an empty FIFO with an idle byte path presents its high byte at edge N+1.
- Sustained rate: 1 byte/cycle with ready held high, so the FIFO fills when words arrive every cycle.
- Simultaneous FIFO push and pop when full: the push is not allowed (ready is low). When the FIFO is empty and the byte path needs a word, it waits.

FSM:
- STREAM
  - Accepts stream words and serialises them.
  - in_flush high: capture in_flag, in_bit_1 and in_bit_2; go to DRAIN. in_word_ready is low from the next cycle.
  - A word handshaken in the same cycle as in_flush is kept and precedes the final words.
- DRAIN
  - When the FIFO is empty and the last stream byte has transferred, go to FINAL if the captured flag is 1 or 2, otherwise go to DONE.
  - A flag value of 3 is treated as 0.
- FINAL
  - Emits in_bit_1 bytes, then in_bit_2 bytes if the flag is 2.
  - out_last is high with the last final byte.
  - After that byte transfers, go to DONE.
- DONE
  - out_done is high for exactly one cycle.
  - Next state is STREAM; out_byte_count clears on that transition.
- in_flush outside STREAM is ignored.

Counter:
- out_byte_count increments on each byte transfer and saturates at all-ones.
- It holds its value through DONE.

Flag-0 frames:
- out_last is never asserted.
- out_done still pulses after the drain completes.

Test Plan:
- Reset, push 0xA1B2 then 0xC3D4 with ready held high -> bytes A1, B2, C3, D4 on consecutive cycles, first byte 1 cycle after acceptance, count = 4.
- Push 6 words back-to-back with out_byte_ready low -> in_word_ready falls after 4 accepted; releasing ready drains 12 bytes in order with no loss or duplication.
- Push 0x1234, flush with flag = 2, in_bit_1 = 0x5566, in_bit_2 = 0x7788 -> bytes 12, 34, 55, 66, 77, 88; out_last only on 88; out_done 1 cycle later; count = 6.
- Flush with flag = 0 (and again with flag = 3) on an empty FIFO -> no bytes, out_done within 2 cycles, out_last never high.
- Toggle out_byte_ready randomly during a flag = 1 frame -> out_byte and out_last stable while stalled; in_flush pulsed during DRAIN is ignored.
- Assert reset in FINAL mid-word -> outputs 0 immediately, no out_done; a following 1-word stream emits correctly from STREAM.
